// File: rtl/pattern_count_engine.sv
// pattern_count_engine
//   Start/done responder that sits beside data memory. A one-cycle reset pulse
//   starts a run: the 5-bit pattern is read from dm[PAT_ADDR][7:3], the string
//   dm[0..N_BYTES-1] is scanned as one MSB-first bit stream, and three counts
//   are written to dm[RES_ADDR..RES_ADDR+2]:
//     ctb - matches fully inside a byte
//     cto - bytes holding at least one in-byte match
//     cts - all matches in the bit stream, including byte-crossing ones
//   done then rises and holds until the next reset.
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high; a pulse is the start request
//   done         results written; held until next reset
//   mem_addr     dm address (read and write)
//   mem_rd_data  dm read data, combinational from mem_addr
//   mem_wr_en    dm write strobe
//   mem_wr_data  dm write data

module pattern_window_match #(
  parameter int PAT_W = 5
) (
  input  logic [PAT_W-1:0] win,
  input  logic [PAT_W-1:0] pat,
  output logic             hit
);
  assign hit = (win == pat);
endmodule

module pattern_count_engine #(
  parameter int N_BYTES  = 32,
  parameter int PAT_ADDR = 32,
  parameter int RES_ADDR = 33,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);
  localparam int PAT_W   = 5;
  localparam int NUM_WIN = 8;   // 4 in-byte windows + 4 crossing windows
  localparam int IW      = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  typedef enum logic [2:0] {LOAD_PAT, SCAN, WR_B, WR_O, WR_S, DONE} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx;
  logic [PAT_W-1:0] pat;
  logic [3:0]      prev;
  logic [7:0]      ctb, cto, cts;

  // x = {prev low nibble, current byte}. Window k is x[k+4:k]:
  // k=0..3 lie inside the byte, k=4..7 straddle the previous byte's tail.
  logic [11:0]         x;
  logic [NUM_WIN-1:0]  hits;
  logic [2:0]          w_in, w_x;
  logic [3:0]          w_s;
  logic                last;

  assign x    = {prev, mem_rd_data};
  assign last = (idx == IW'(N_BYTES - 1));

  for (genvar k = 0; k < NUM_WIN; k++) begin : g_win
    pattern_window_match #(.PAT_W(PAT_W)) u_win (
      .win (x[k+PAT_W-1:k]),
      .pat (pat),
      .hit (hits[k])
    );
  end

  always_comb begin
    w_in = '0;
    w_x  = '0;
    for (int k = 0; k < 4; k++) begin
      w_in = w_in + {2'b0, hits[k]};
      w_x  = w_x  + {2'b0, hits[k+4]};
    end
    // Byte 0 heads the stream: prev is stale/cleared, so no crossing term.
    w_s = {1'b0, w_in} + ((idx != '0) ? {1'b0, w_x} : 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD_PAT;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat  <= '0;
      idx  <= '0;
      prev <= '0;
      ctb  <= '0;
      cto  <= '0;
      cts  <= '0;
    end else begin
      case (state)
        LOAD_PAT: begin
          pat <= mem_rd_data[7:3];
          idx <= '0;
        end
        SCAN: begin
          ctb  <= ctb + {5'b0, w_in};
          cto  <= cto + {7'b0, (w_in != '0)};
          cts  <= cts + {4'b0, w_s};
          prev <= mem_rd_data[3:0];
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; reset reaches them one edge later.
  always_comb begin
    state_n     = state;
    mem_addr    = AW'(PAT_ADDR);
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    done        = 1'b0;
    case (state)
      LOAD_PAT: state_n = SCAN;
      SCAN: begin
        mem_addr = AW'(idx);
        if (last) state_n = WR_B;
      end
      WR_B: begin
        mem_addr    = AW'(RES_ADDR);
        mem_wr_en   = 1'b1;
        mem_wr_data = ctb;
        state_n     = WR_O;
      end
      WR_O: begin
        mem_addr    = AW'(RES_ADDR + 1);
        mem_wr_en   = 1'b1;
        mem_wr_data = cto;
        state_n     = WR_S;
      end
      WR_S: begin
        mem_addr    = AW'(RES_ADDR + 2);
        mem_wr_en   = 1'b1;
        mem_wr_data = cts;
        state_n     = DONE;
      end
      DONE: done = 1'b1;
      default: state_n = LOAD_PAT;
    endcase
  end
endmodule

// File: tb/tb_pattern_count_engine.sv
module tb_pattern_count_engine;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [7:0] str [32];
  logic [7:0] pat_byte;
  int         wa_q[$];
  int         wd_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  pattern_count_engine #(.N_BYTES(32), .PAT_ADDR(32), .RES_ADDR(33), .AW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  // Data memory: string and pattern are read-only here; writes are logged.
  always_comb begin
    mem_rd_data = 8'h00;
    if (mem_addr < 8'd32)       mem_rd_data = str[mem_addr[4:0]];
    else if (mem_addr == 8'd32) mem_rd_data = pat_byte;
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      wa_q.push_back(int'(mem_addr));
      wd_q.push_back(int'(mem_wr_data));
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Golden: slide a 5-bit window over the 256-bit MSB-first stream.
  function automatic void gold(output int eb, output int eo, output int es);
    logic [255:0] bits;
    logic [31:0]  hitbyte;
    logic [4:0]   p5;
    eb = 0; eo = 0; es = 0; hitbyte = '0;
    p5 = pat_byte[7:3];
    for (int i = 0; i < 32; i++) bits[255-8*i -: 8] = str[i];
    for (int p = 0; p < 252; p++) begin
      if (bits[255-p -: 5] == p5) begin
        es++;
        if ((p % 8) <= 3) begin
          eb++;
          hitbyte[p/8] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 32; i++) eo += int'(hitbyte[i]);
  endfunction

  task automatic run_chk(input string tag, input int eb, input int eo, input int es,
                         input bit chk_rst);
    int n0, cyc;
    n0 = wa_q.size();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    if (chk_rst) begin
      chk("rst_done", int'(done), 0);
      chk("rst_we", int'(mem_wr_en), 0);
      chk("rst_addr", int'(mem_addr), 32);
    end
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, cyc, 36);
    chk({tag, "_nwr"}, wa_q.size() - n0, 3);
    if (wa_q.size() - n0 == 3) begin
      chk({tag, "_a33"}, wa_q[n0],   33);
      chk({tag, "_a34"}, wa_q[n0+1], 34);
      chk({tag, "_a35"}, wa_q[n0+2], 35);
      chk({tag, "_ctb"}, wd_q[n0],   eb);
      chk({tag, "_cto"}, wd_q[n0+1], eo);
      chk({tag, "_cts"}, wd_q[n0+2], es);
    end
    repeat (2) @(negedge clk);
    chk({tag, "_hold"}, int'(done), 1);
    chk({tag, "_nwr2"}, wa_q.size() - n0, 3);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 32; i++) str[i] = v;
  endtask

  initial begin
    int eb, eo, es, n0;
    fill(8'h00);
    pat_byte = 8'h00;
    repeat (3) @(negedge clk);

    // 1: all-zero pattern over all-zero string
    fill(8'h00); pat_byte = 8'b00000_000;
    run_chk("t1", 128, 32, 252, 1'b1);

    // 2: 10101 over 0x55
    fill(8'h55); pat_byte = 8'b10101_000;
    run_chk("t2", 64, 32, 126, 1'b0);

    // 3: 11111 over 0xFF (low pattern-byte bits must be ignored)
    fill(8'hFF); pat_byte = 8'b11111_101;
    run_chk("t3", 128, 32, 252, 1'b0);

    // 4: crossing-only match between byte 0 and byte 1
    fill(8'h00); str[0] = 8'h0F; str[1] = 8'h80; pat_byte = 8'b11111_000;
    run_chk("t4", 0, 0, 1, 1'b0);

    // 6: abort mid-scan, then a clean run
    fill(8'hA5); pat_byte = 8'b01011_000;
    gold(eb, eo, es);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    n0 = wa_q.size();
    repeat (10) @(negedge clk);
    chk("abort_done", int'(done), 0);
    chk("abort_nwr", wa_q.size() - n0, 0);
    run_chk("t6", eb, eo, es, 1'b1);

    // 5: random patterns and strings against the golden model
    for (int r = 0; r < 200; r++) begin
      for (int i = 0; i < 32; i++) str[i] = 8'($urandom);
      if (r % 4 == 0) for (int i = 0; i < 32; i++) str[i] = str[i] & 8'h0F;
      pat_byte = 8'($urandom);
      gold(eb, eo, es);
      run_chk("rnd", eb, eo, es, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
